// File: rtl/comp_seq_ctrl_pkg.sv
// rtl/comp_seq_ctrl_pkg.sv - shared types and widths for the comparator sequencer
`include "consts_train.vh"

package comp_seq_ctrl_pkg;

  localparam int CSC_DATA_W = `N * `CHAR_NUM * `N_LEN;
  localparam int CSC_NUM_W  = `N * `CHAR_LEN;
  localparam int CSC_Q_W    = `N * `N_LEN;
  localparam int CSC_TMR_W  = 16;

  typedef enum logic [1:0] {
    CSC_S_IDLE = `CSC_IDLE,
    CSC_S_RUN  = `CSC_RUN,
    CSC_S_WAIT = `CSC_WAIT,
    CSC_S_OUT  = `CSC_OUT
  } csc_state_e;

endpackage

// File: rtl/comp_seq_timer.sv
// rtl/comp_seq_timer.sv - WAIT-state cycle counter with stale-valid guard and timeout compare
module comp_seq_timer
  import comp_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int MIN_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic accept_en,
  output logic expired
);

  logic [CSC_TMR_W-1:0] cnt_q;
  logic [CSC_TMR_W-1:0] cnt_d;

  // Hold at all-ones so a stray long enable cannot wrap back under MIN_LAT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign accept_en = (cnt_q >= CSC_TMR_W'(MIN_LAT));
  assign expired   = (cnt_q == CSC_TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/consts_train.vh
// rtl/consts_train.vh - shared training datapath widths and comparator sequencer state codes
`ifndef CONSTS_TRAIN_VH
`define CONSTS_TRAIN_VH

`define N        4
`define CHAR_NUM 4
`define N_LEN    8
`define CHAR_LEN 2

`define CSC_IDLE 2'd0
`define CSC_RUN  2'd1
`define CSC_WAIT 2'd2
`define CSC_OUT  2'd3

`endif

// File: rtl/comp_seq_ctrl.sv
// rtl/comp_seq_ctrl.sv - sequencer feeding score blocks to the argmax comparator layer
module comp_seq_ctrl
  import comp_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int MIN_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CSC_DATA_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  comp_run,
  output logic [CSC_DATA_W-1:0] comp_d,
  input  logic                  comp_valid,
  input  logic [CSC_NUM_W-1:0]  comp_num,
  input  logic [CSC_Q_W-1:0]    comp_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CSC_NUM_W-1:0]  out_num,
  output logic [CSC_Q_W-1:0]    out_q,
  output logic                  out_last,
  output logic                  out_err,
  output logic [CNT_W-1:0]      blk_cnt,
  output logic                  busy
);

  csc_state_e            state_q, state_d;
  logic [CSC_DATA_W-1:0] comp_d_q, comp_d_d;
  logic                  last_q, last_d;
  logic [CSC_NUM_W-1:0]  out_num_q, out_num_d;
  logic [CSC_Q_W-1:0]    out_q_q, out_q_d;
  logic                  out_err_q, out_err_d;
  logic [CNT_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  accept_en;
  logic                  expired;

  comp_seq_timer #(
    .TIMEOUT (TIMEOUT),
    .MIN_LAT (MIN_LAT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q == CSC_S_RUN),
    .en        (state_q == CSC_S_WAIT),
    .accept_en (accept_en),
    .expired   (expired)
  );

  always_comb begin
    state_d   = state_q;
    comp_d_d  = comp_d_q;
    last_d    = last_q;
    out_num_d = out_num_q;
    out_q_d   = out_q_q;
    out_err_d = out_err_q;
    blk_cnt_d = blk_cnt_q;
    case (state_q)
      CSC_S_IDLE: begin
        if (in_valid) begin
          comp_d_d = in_data;
          last_d   = in_last;
          state_d  = CSC_S_RUN;
        end
      end
      CSC_S_RUN: begin
        state_d = CSC_S_WAIT;
      end
      CSC_S_WAIT: begin
        // A real result beats a timeout landing on the same cycle.
        if (comp_valid && accept_en) begin
          out_num_d = comp_num;
          out_q_d   = comp_q;
          out_err_d = 1'b0;
          state_d   = CSC_S_OUT;
        end else if (expired) begin
          out_num_d = '0;
          out_q_d   = '0;
          out_err_d = 1'b1;
          state_d   = CSC_S_OUT;
        end
      end
      CSC_S_OUT: begin
        if (out_ready) begin
          state_d = CSC_S_IDLE;
          if (last_q) begin
            blk_cnt_d = '0;
          end else if (blk_cnt_q != '1) begin
            blk_cnt_d = blk_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = CSC_S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CSC_S_IDLE;
      comp_d_q  <= '0;
      last_q    <= 1'b0;
      out_num_q <= '0;
      out_q_q   <= '0;
      out_err_q <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      comp_d_q  <= comp_d_d;
      last_q    <= last_d;
      out_num_q <= out_num_d;
      out_q_q   <= out_q_d;
      out_err_q <= out_err_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign in_ready  = (state_q == CSC_S_IDLE);
  assign comp_run  = (state_q == CSC_S_RUN);
  assign out_valid = (state_q == CSC_S_OUT);
  assign busy      = (state_q != CSC_S_IDLE);
  assign out_last  = (state_q == CSC_S_OUT) && last_q;
  assign comp_d    = comp_d_q;
  assign out_num   = out_num_q;
  assign out_q     = out_q_q;
  assign out_err   = out_err_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// tb/tb_comp_seq_ctrl.sv - directed self-checking bench for comp_seq_ctrl
module tb_comp_seq_ctrl;
  import comp_seq_ctrl_pkg::*;

  localparam int DW = CSC_DATA_W;
  localparam int NW = CSC_NUM_W;
  localparam int QW = CSC_Q_W;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          comp_run;
  logic [DW-1:0] comp_d;
  logic          comp_valid;
  logic [NW-1:0] comp_num;
  logic [QW-1:0] comp_q;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] out_num;
  logic [QW-1:0] out_q;
  logic          out_last;
  logic          out_err;
  logic [CW-1:0] blk_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int run_cnt = 0;
  int run_before;
  logic bad;

  comp_seq_ctrl #(
    .TIMEOUT (16),
    .MIN_LAT (1),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .comp_run   (comp_run),
    .comp_d     (comp_d),
    .comp_valid (comp_valid),
    .comp_num   (comp_num),
    .comp_q     (comp_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_num    (out_num),
    .out_q      (out_q),
    .out_last   (out_last),
    .out_err    (out_err),
    .blk_cnt    (blk_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (comp_run === 1'b1) run_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Normal block: comparator answers lat cycles after the run pulse, out_ready high.
  task automatic do_block(input string tag, input logic [DW-1:0] d, input logic last, input int lat,
                          input logic [NW-1:0] num, input logic [QW-1:0] q,
                          input logic [CW-1:0] exp_cnt);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick;
    in_valid = 1'b0;
    chk({tag, ".run"}, comp_run, 1'b1);
    chk({tag, ".comp_d"}, comp_d, d);
    repeat (lat - 1) tick;
    tick;
    comp_valid = 1'b1; comp_num = num; comp_q = q;
    chk({tag, ".no_early_valid"}, out_valid, 1'b0);
    tick;
    comp_valid = 1'b0;
    chk({tag, ".out_valid"}, out_valid, 1'b1);
    chk({tag, ".out_num"}, out_num, num);
    chk({tag, ".out_q"}, out_q, q);
    chk({tag, ".out_last"}, out_last, last);
    chk({tag, ".out_err"}, out_err, 1'b0);
    tick;
    chk({tag, ".idle"}, out_valid, 1'b0);
    chk({tag, ".blk_cnt"}, blk_cnt, exp_cnt);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1'b1);
    chk({tag, ".comp_run"}, comp_run, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".out_valid"}, out_valid, 1'b0);
    chk({tag, ".out_last"}, out_last, 1'b0);
    chk({tag, ".out_err"}, out_err, 1'b0);
    chk({tag, ".comp_d"}, comp_d, '0);
    chk({tag, ".out_num"}, out_num, '0);
    chk({tag, ".out_q"}, out_q, '0);
    chk({tag, ".blk_cnt"}, blk_cnt, '0);
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    comp_valid = 1'b0; comp_num = '0; comp_q = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    release_reset;

    // Single block, comparator answers 5 cycles after run
    do_block("single", 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b0, 5,
             8'hb4, 32'hc0de_1234, 2'd1);
    chk("single.one_run", run_cnt, 1);

    // Stale valid held through RUN and first WAIT cycle must be ignored
    in_valid = 1'b1; in_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888; in_last = 1'b0;
    comp_valid = 1'b1; comp_num = 8'hff; comp_q = 32'hdead_beef;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    comp_valid = 1'b0;
    tick;
    comp_valid = 1'b1; comp_num = 8'h27; comp_q = 32'h0a0b_0c0d;
    tick;
    comp_valid = 1'b0;
    chk("stale.out_valid", out_valid, 1'b1);
    chk("stale.out_num", out_num, 8'h27);
    chk("stale.out_q", out_q, 32'h0a0b_0c0d);
    tick;
    chk("stale.blk_cnt", blk_cnt, 2'd2);

    // Timeout: no comparator response
    in_valid = 1'b1; in_data = 128'h3; in_last = 1'b0;
    tick;
    in_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("timeout.quiet_wait", bad, 1'b0);
    tick;
    chk("timeout.out_valid", out_valid, 1'b1);
    chk("timeout.out_err", out_err, 1'b1);
    chk("timeout.out_num", out_num, '0);
    chk("timeout.out_q", out_q, '0);
    tick;
    chk("timeout.blk_cnt", blk_cnt, 2'd3);

    // Next block clears out_err; block count saturates at all-ones
    do_block("sat", 128'h4444, 1'b0, 3, 8'h5a, 32'h1357_9bdf, 2'd3);

    // Backpressure on the last block of a frame
    out_ready = 1'b0;
    run_before = run_cnt;
    in_valid = 1'b1; in_data = 128'h00aa_00bb; in_last = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    comp_valid = 1'b1; comp_num = 8'h9c; comp_q = 32'h8765_4321;
    tick;
    comp_valid = 1'b0;
    chk("bp.out_valid", out_valid, 1'b1);
    chk("bp.out_last", out_last, 1'b1);
    in_valid = 1'b1; in_data = 128'hffff;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid !== 1'b1 || out_num !== 8'h9c || out_q !== 32'h8765_4321 ||
          in_ready !== 1'b0 || comp_d !== 128'h00aa_00bb) bad = 1'b1;
    end
    chk("bp.stable", bad, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp.idle", out_valid, 1'b0);
    chk("bp.blk_cnt", blk_cnt, 2'd0);
    chk("bp.one_run", run_cnt, run_before + 1);

    // Frame of three blocks
    do_block("frame0", 128'h10, 1'b0, 2, 8'h01, 32'h0000_0011, 2'd1);
    do_block("frame1", 128'h20, 1'b0, 4, 8'h02, 32'h0000_0022, 2'd2);
    do_block("frame2", 128'h30, 1'b1, 2, 8'h03, 32'h0000_0033, 2'd0);

    // Reset during RUN drops comp_run immediately
    in_valid = 1'b1; in_data = 128'h77; in_last = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("rst_run.pre", comp_run, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_run");
    release_reset;

    // Reset during WAIT discards the block
    do_block("pre_rst", 128'h88, 1'b0, 2, 8'h44, 32'h4444_4444, 2'd1);
    in_valid = 1'b1; in_data = 128'h99; in_last = 1'b0;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    release_reset;
    do_block("post_rst", 128'hab, 1'b0, 3, 8'h66, 32'h6666_0000, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_seq_ctrl.md
Name: comp_seq_ctrl

Overview:
- Sequencer for the N-row argmax comparator layer (`comp_layer`) in the training datapath.
- Accepts score blocks from upstream over a valid/ready handshake and registers each block.
- For each block it pulses the layer's run, waits for the layer's valid, then captures the argmax indices and max values into an output register.
- Presents results downstream over valid/ready, tracks frame boundaries, and flags a comparator timeout.

Parameters:
- TIMEOUT, 256: max WAIT cycles before abort; 1..65535.
- MIN_LAT, 1: WAIT cycles during which comp_valid is ignored (stale-valid guard); 0..TIMEOUT-1.
- CNT_W, 16: width of blk_cnt.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream block available.
- in_ready  out  1  controller can accept a block.
- in_data  in  `N*`CHAR_NUM*`N_LEN  N rows of CHAR_NUM scores; row i at [i*`CHAR_NUM*`N_LEN +: `CHAR_NUM*`N_LEN].
- in_last  in  1  block is last of frame.
- comp_run  out  1  run pulse to comparator layer.
- comp_d  out  `N*`CHAR_NUM*`N_LEN  registered block to comparator layer.
- comp_valid  in  1  comparator layer result valid.
- comp_num  in  `N*`CHAR_LEN  per-row argmax index.
- comp_q  in  `N*`N_LEN  per-row max value.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_num  out  `N*`CHAR_LEN  captured indices.
- out_q  out  `N*`N_LEN  captured maxima.
- out_last  out  1  result belongs to the last block of the frame.
- out_err  out  1  result is from a timeout; out_num/out_q are zero.
- blk_cnt  out  CNT_W  blocks completed in the current frame.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1 and comp_run=0; out_valid, out_last, out_err, busy=0; comp_d, out_num, out_q=0; blk_cnt=0; wait counter=0.
- FSM states: IDLE, RUN, WAIT, OUT. All outputs are registered or decoded from state only. No combinational path from input to output.
- IDLE: in_ready=1. On in_valid: latch in_data into comp_d and in_last into last_r, then go to RUN.
- RUN: comp_run=1 for exactly this one cycle; clear the wait counter; go to WAIT.
- WAIT: the wait counter increments each cycle.
  - comp_valid is ignored while counter < MIN_LAT.
  - When counter >= MIN_LAT and comp_valid=1: capture comp_num/comp_q into out_num/out_q, set out_err=0, go to OUT.
  - Otherwise, when counter == TIMEOUT-1: zero out_num/out_q, set out_err=1, go to OUT.
  - If comp_valid and the timeout coincide, valid wins.
- OUT: out_valid=1; out_last=last_r. Data is held stable until out_ready.
  - On out_ready: go to IDLE, then update blk_cnt: if last_r, blk_cnt=0; else blk_cnt+1. blk_cnt saturates at all-ones and does not wrap.
- Latency: in handshake at cycle t, then comp_run at t+1, earliest capture at t+2+MIN_LAT, out_valid one cycle after capture.
- Throughput: one block in flight. in_ready=0 in RUN, WAIT and OUT. No skid buffer.
- comp_run is never asserted outside RUN. comp_d is stable from RUN until the next IDLE accept.
- out_err persists only with its own result. It is cleared on the next capture.
- Mid-operation reset: returns to IDLE immediately. Any in-flight result is discarded, and comp_run deasserts asynchronously.

Decomposition:
- Widths come from the shared consts_train.vh macros (`N, `CHAR_NUM, `N_LEN, `CHAR_LEN). Add state encodings (`CSC_IDLE.. `CSC_OUT, 2 bits) to the same shared header.
- One natural sub-module: comp_seq_timer, the wait counter with MIN_LAT guard and TIMEOUT compare. It outputs accept_en and expired.
- The controller top instantiates comp_seq_timer only. comp_layer is instantiated by the parent, next to this block.

Test Plan:
- Single block, MIN_LAT=1, comparator model asserts valid 5 cycles after run, out_ready=1 -> one comp_run pulse; out_valid exactly 1 cycle after capture; out_num/out_q match the model; blk_cnt 0->1; out_err=0.
- Stale valid: comp_valid held at 1 through RUN and the first WAIT cycle, model result appears at cycle 3 -> the cycle-3 value is captured, not the stale one.
- Timeout, TIMEOUT=16, comp_valid never asserted -> out_valid 16 cycles after entering WAIT; out_err=1; out_num=out_q=0; next block gets out_err=0.
- Backpressure: out_ready low for 10 cycles -> out_valid/out_num stable; in_ready=0 throughout; no second comp_run.
- Frame of 3 blocks, in_last on the 3rd -> out_last only on the 3rd result; blk_cnt 1,2 then 0.
- rst_n pulsed low during WAIT -> all outputs at reset values within the same cycle; the next block completes normally.
